stream_demux4: RTL
==================

Name: stream_demux4

Overview:
- 1-to-4 stream demultiplexer: routes each input beat to one of four output lanes, chosen by a 2-bit select carried with the beat.
- Each lane holds one registered entry with its own valid/ready handshake.
- A per-lane 16-bit beat counter gives status and debug visibility.
- Sits downstream of a single producer and fans traffic out to four independent consumers. It is the routing counterpart of the team's 4:1 select mux.

Parameters:
WIDTH, 8, data width of in_data and each out_data lane

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  input beat present
in_ready  output  1  block can accept the beat this cycle
in_data  input  WIDTH  input payload
in_sel  input  2  destination lane for the beat (2'b00..2'b11 -> lane 0..3)
out_valid  output  4  bit i = lane i holds a beat
out_ready  input  4  bit i = consumer i accepts lane i this cycle
out_data0  output  WIDTH  lane 0 payload
out_data1  output  WIDTH  lane 1 payload
out_data2  output  WIDTH  lane 2 payload
out_data3  output  WIDTH  lane 3 payload
beat_cnt0..beat_cnt3  output  16 each  number of beats delivered on lane i (out_valid[i] & out_ready[i])

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high; it takes effect immediately, regardless of clk.
- Reset values: out_valid=4'b0000, out_data0..3=0, beat_cnt0..3=0. in_ready is combinational and reads 1 during reset.
- Lane storage: lane i is a one-entry register (out_data_i, out_valid[i]).
- in_ready (combinational): in_ready = !out_valid[in_sel] | out_ready[in_sel].
  - The input is ready if the selected lane is empty, or is being drained in the same cycle.
  - in_ready depends only on the selected lane.
- Accept: a beat is accepted when in_valid & in_ready at the clk edge. On the next edge, out_data_{in_sel} <= in_data and out_valid[in_sel] <= 1.
- Latency: exactly 1 cycle from acceptance to out_valid.
- Deliver: lane i transfers when out_valid[i] & out_ready[i].
  - If lane i is not loaded in the same cycle, out_valid[i] <= 0 and out_data_i holds its value.
  - beat_cnt_i increments by 1 on every transfer.
  - beat_cnt_i wraps 16'hFFFF -> 16'h0000 with no flag.
- Simultaneous load and drain on the same lane: the new beat is loaded, out_valid[i] stays 1, and the old beat is counted. This gives full throughput of one beat per cycle.
- Simultaneous activity on different lanes: loading lane j and draining lane k (k != j) in one cycle are independent and both take effect.
- Stall (lane full and not ready):
  - out_data_i and out_valid[i] are held stable.
  - Input beats targeting that lane are back-pressured (in_ready=0).
  - The producer must hold in_valid, in_data and in_sel stable until acceptance.
  - Other lanes keep draining.
- in_valid=0: in_sel and in_data are ignored. No state change other than drains.
- No data is dropped or duplicated. Ordering is preserved within each lane; no ordering is guaranteed across lanes.
- Reset mid-operation: all buffered beats are discarded, out_valid clears immediately, and counters clear. Any beat presented in the cycle rst deasserts is accepted only at the first clk edge with rst low.
- Out-of-range input is impossible: in_sel is 2 bits and all four codes are valid.

Test Plan:
- Reset then idle:
  - Stimulus: rst=1 for 3 cycles mid-stream (lane 2 holding 8'hA5, cnt2=5).
  - Response: out_valid=0000 and all out_data/beat_cnt=0 immediately on rst rise; in_ready=1.
- Routing sweep:
  - Stimulus: all out_ready=1; send in_sel=0,1,2,3 with data 8'h10,8'h21,8'h32,8'h43 on consecutive cycles.
  - Response: each appears on lanes 0..3 one cycle later with a single out_valid bit; in_ready stays 1; beat_cnt0..3=1.
- Back-pressure:
  - Stimulus: out_ready[1]=0; send 8'h55 to lane 1, then 8'h66 to lane 1.
  - Response: out_data1 holds 8'h55; in_ready=0 while presenting the second beat.
  - Then: assert out_ready[1].
  - Response: 8'h66 accepted in that same cycle, visible next cycle; cnt1=1, then 2 after its drain.
- No head-of-line blocking between lanes:
  - Stimulus: lane 3 full and stalled; send 8'h77 to lane 0.
  - Response: accepted immediately; lane 3 data unchanged.
- Full throughput on one lane:
  - Stimulus: out_ready[2]=1; 10 back-to-back beats 0..9 to lane 2.
  - Response: out_valid[2] stays 1 for 10 cycles; data 0..9 in order; cnt2=10.
- Counter wrap:
  - Stimulus: deliver 65537 beats on lane 0.
  - Response: beat_cnt0 = 16'h0001.

Source files
------------

// File: rtl/stream_demux4.sv
// 1:4 stream demux with one registered entry per lane; 1-cycle accept-to-valid latency.
// in_ready backpressures only on the selected lane; a full lane that is draining still accepts.
module stream_demux4 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_sel,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [WIDTH-1:0] out_data0,
  output logic [WIDTH-1:0] out_data1,
  output logic [WIDTH-1:0] out_data2,
  output logic [WIDTH-1:0] out_data3,
  output logic [15:0]      beat_cnt0,
  output logic [15:0]      beat_cnt1,
  output logic [15:0]      beat_cnt2,
  output logic [15:0]      beat_cnt3
);

  logic [WIDTH-1:0] lane_dat [4];
  logic [15:0]      lane_cnt [4];
  logic             accept;
  logic [3:0]       load;
  logic [3:0]       drain;

  assign in_ready = !out_valid[in_sel] | out_ready[in_sel];
  assign accept   = in_valid & in_ready;
  assign load     = {4{accept}} & (4'b0001 << in_sel);
  assign drain    = out_valid & out_ready;

  // Load wins over drain so a lane can refill in the same cycle it empties.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 4'b0000;
      for (int i = 0; i < 4; i++) begin
        lane_dat[i] <= '0;
        lane_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (load[i]) begin
          lane_dat[i]  <= in_data;
          out_valid[i] <= 1'b1;
        end else if (drain[i]) begin
          out_valid[i] <= 1'b0;
        end
        if (drain[i]) begin
          lane_cnt[i] <= lane_cnt[i] + 16'd1;
        end
      end
    end
  end

  assign out_data0 = lane_dat[0];
  assign out_data1 = lane_dat[1];
  assign out_data2 = lane_dat[2];
  assign out_data3 = lane_dat[3];
  assign beat_cnt0 = lane_cnt[0];
  assign beat_cnt1 = lane_cnt[1];
  assign beat_cnt2 = lane_cnt[2];
  assign beat_cnt3 = lane_cnt[3];

endmodule
